// File: rtl/trg_pkg.sv
// Shared types and cfg word layout for the SUMP-style trigger stages.
package trg_pkg;

    localparam int TRG_DLY_LSB    = 0;
    localparam int TRG_DLY_W      = 16;
    localparam int TRG_LVL_LSB    = 16;
    localparam int TRG_LVL_W      = 2;
    localparam int TRG_CHAN_LSB   = 20;
    localparam int TRG_CHAN_W     = 5;
    localparam int TRG_SERIAL_BIT = 26;
    localparam int TRG_START_BIT  = 27;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        FIRED = 2'd3
    } trg_state_e;

    // Field order mirrors the bit offsets above, MSB first.
    typedef struct packed {
        logic [3:0]            rsvd_31_28;
        logic                  start;
        logic                  serial;
        logic                  rsvd_25;
        logic [TRG_CHAN_W-1:0] channel;
        logic [1:0]            rsvd_19_18;
        logic [TRG_LVL_W-1:0]  level;
        logic [TRG_DLY_W-1:0]  delay;
    } trg_cfg_t;

endpackage

// File: rtl/trigger_match.sv
// Masked value compare for one trigger stage; serial-channel shift register
// is compiled in only when TRG_SERIAL_EN is defined.
module trigger_match
    import trg_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  shift_i,
    input  logic                  serial_i,
    input  logic [TRG_CHAN_W-1:0] chan_i,
    input  logic [DW-1:0]         smpls_i,
    input  logic [DW-1:0]         mask_i,
    input  logic [DW-1:0]         val_i,
    output logic                  hit_o
);

    logic [DW-1:0] cmp;

`ifdef TRG_SERIAL_EN
    logic [DW-1:0] sr_q;
    logic [DW-1:0] sr_next;
    logic          new_bit;

    assign new_bit = smpls_i[chan_i];
    // The incoming bit takes part in the compare of the same strobe.
    assign sr_next = {sr_q[DW-2:0], new_bit};

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sr_q <= '0;
        end else if (shift_i) begin
            sr_q <= sr_next;
        end
    end

    assign cmp = serial_i ? sr_next : smpls_i;
`else
    logic unused_serial;
    assign unused_serial = ^{clk_i, rst_i, clr_i, shift_i, serial_i, chan_i};
    assign cmp = smpls_i;
`endif

    assign hit_o = (((cmp ^ val_i) & mask_i) == '0);

endmodule

// File: rtl/trigger_stage.sv
// One trigger stage: level-gated masked match, optional strobe delay, then
// lvl_inc_o or run_o. Optional serial compare via TRG_SERIAL_EN.
module trigger_stage
    import trg_pkg::*;
#(
    parameter int DW   = 32,
    parameter int DLYW = 16,
    parameter int LVLW = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            arm_i,
    input  logic            set_mask_i,
    input  logic            set_val_i,
    input  logic            set_cfg_i,
    input  logic [31:0]     cfg_i,
    input  logic            stb_i,
    input  logic [DW-1:0]   smpls_i,
    input  logic [LVLW-1:0] lvl_i,
    output logic            armed_o,
    output logic            lvl_inc_o,
    output logic            run_o
);

    logic [DW-1:0]   mask_q;
    logic [DW-1:0]   val_q;
    trg_cfg_t        cfg_q;
    logic [DLYW-1:0] cnt_q;
    logic [DLYW-1:0] cnt_d;
    logic [DLYW-1:0] delay_v;
    trg_state_e      state_q;
    trg_state_e      state_d;
    logic            run_d;
    logic            inc_d;
    logic            run_p1;
    logic            inc_p1;
    logic            hit;
    logic            lvl_ok;
    logic            armed_stb;
    logic            match_p0;
    logic            unused_cfg;

    assign unused_cfg = ^{cfg_q.rsvd_31_28, cfg_q.rsvd_25, cfg_q.rsvd_19_18};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '0;
            val_q  <= '0;
            cfg_q  <= '0;
        end else begin
            if (set_mask_i) mask_q <= DW'(cfg_i);
            if (set_val_i)  val_q  <= DW'(cfg_i);
            if (set_cfg_i)  cfg_q  <= trg_cfg_t'(cfg_i);
        end
    end

    // An arm in the same cycle as a strobe suppresses evaluation of that strobe.
    assign armed_stb = (state_q == ARMED) && stb_i && !arm_i;

    trigger_match #(
        .DW (DW)
    ) u_match (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (arm_i),
        .shift_i  (armed_stb),
        .serial_i (cfg_q.serial),
        .chan_i   (cfg_q.channel),
        .smpls_i  (smpls_i),
        .mask_i   (mask_q),
        .val_i    (val_q),
        .hit_o    (hit)
    );

    // Unsigned compare in a wide domain so unreachable levels never match.
    assign lvl_ok   = 32'(lvl_i) >= 32'(cfg_q.level);
    assign match_p0 = armed_stb && lvl_ok && hit;
    assign delay_v  = DLYW'(cfg_q.delay);

    // ---- stage p0 -> p1: state, counter and registered pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_p1  <= 1'b0;
            inc_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_p1  <= run_d;
            inc_p1  <= inc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm_i) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                ARMED: begin
                    if (match_p0) begin
                        if (cfg_q.start && delay_v != '0) state_d = DELAY;
                        else                              state_d = FIRED;
                    end
                end
                DELAY: begin
                    if (stb_i && cnt_q == DLYW'(1)) state_d = FIRED;
                end
                FIRED: state_d = FIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        run_d = 1'b0;
        inc_d = 1'b0;
        cnt_d = cnt_q;
        if (arm_i) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (match_p0) begin
                        if (!cfg_q.start)         inc_d = 1'b1;
                        else if (delay_v == '0)   run_d = 1'b1;
                        else                      cnt_d = delay_v;
                    end
                end
                DELAY: begin
                    if (stb_i) begin
                        if (cnt_q == DLYW'(1)) begin
                            run_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q - DLYW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- stage p1: outputs
    assign armed_o   = (state_q == ARMED) || (state_q == DELAY);
    assign run_o     = run_p1;
    assign lvl_inc_o = inc_p1;

endmodule

// File: tb/tb_trigger_stage.sv
// Scoreboard bench for trigger_stage: directed vectors push expected pulses,
// an independent monitor pops and compares on every output pulse.
module tb_trigger_stage;

    localparam int DW   = 32;
    localparam int DLYW = 16;
    localparam int LVLW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            arm;
    logic            set_mask;
    logic            set_val;
    logic            set_cfg;
    logic [31:0]     cfg;
    logic            stb;
    logic [DW-1:0]   smpls;
    logic [LVLW-1:0] lvl;
    logic            armed;
    logic            lvl_inc;
    logic            run;

    trigger_stage #(.DW(DW), .DLYW(DLYW), .LVLW(LVLW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .arm_i      (arm),
        .set_mask_i (set_mask),
        .set_val_i  (set_val),
        .set_cfg_i  (set_cfg),
        .cfg_i      (cfg),
        .stb_i      (stb),
        .smpls_i    (smpls),
        .lvl_i      (lvl),
        .armed_o    (armed),
        .lvl_inc_o  (lvl_inc),
        .run_o      (run)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_run;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mcyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        mcyc++;
        if (run || lvl_inc) begin
            chk("pulse_exclusive", {31'd0, run & lvl_inc}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output run=%b lvl_inc=%b cycle=%0d required none", run, lvl_inc, mcyc);
            end else begin
                e = q.pop_front();
                chk("out_is_run", {31'd0, run}, {31'd0, e.is_run});
                chk("out_cycle", mcyc, e.cyc);
            end
        end else if (q.size() > 0 && q[0].cyc <= mcyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_output actual=none required=%s at cycle %0d", e.is_run ? "run" : "lvl_inc", e.cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int which, input logic [31:0] d);
        cfg      = d;
        set_mask = (which == 0);
        set_val  = (which == 1);
        set_cfg  = (which == 2);
        tick(1);
        set_mask = 1'b0;
        set_val  = 1'b0;
        set_cfg  = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    // exp: 0 none, 1 run_o expected next cycle, 2 lvl_inc_o expected next cycle
    task automatic sample(input logic [DW-1:0] v, input int exp);
        smpls = v;
        stb   = 1'b1;
        if (exp != 0) q.push_back('{is_run: (exp == 1), cyc: mcyc + 1});
        tick(1);
        stb = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; set_mask = 1'b0; set_val = 1'b0; set_cfg = 1'b0;
        cfg = '0; stb = 1'b0; smpls = '0; lvl = '0;
        tick(3);
        chk("reset_armed", {31'd0, armed}, 32'd0);
        chk("reset_run", {31'd0, run}, 32'd0);
        chk("reset_lvl_inc", {31'd0, lvl_inc}, 32'd0);
        rst = 1'b0;
        tick(1);

        // 1. parallel match, start, no delay
        wr(0, 32'h0000_00FF);
        wr(1, 32'h0000_00A5);
        wr(2, 32'h0800_0000);
        do_arm();
        chk("t1_armed", {31'd0, armed}, 32'd1);
        sample(32'h0000_0000, 0);
        sample(32'h0000_01A5, 1);
        tick(3);
        chk("t1_fired_not_armed", {31'd0, armed}, 32'd0);

        // 2. level gating, level increment request
        wr(2, 32'h0001_0000);
        do_arm();
        lvl = 2'd0;
        sample(32'h0000_00A5, 0);
        sample(32'h0000_00A5, 0);
        tick(2);
        chk("t2_still_armed", {31'd0, armed}, 32'd1);
        lvl = 2'd1;
        sample(32'h0000_00A5, 2);
        sample(32'h0000_00A5, 0);
        tick(2);
        sample(32'h0000_00A5, 0);
        tick(2);
        lvl = 2'd0;

        // 3. delay of 3 with gapped strobes
        wr(2, 32'h0800_0003);
        do_arm();
        sample(32'h0000_00A5, 0);
        chk("t3_delay_armed", {31'd0, armed}, 32'd1);
        tick(3);
        sample(32'h0000_0000, 0);
        tick(3);
        sample(32'h0000_0000, 0);
        tick(3);
        chk("t3_still_delay", {31'd0, armed}, 32'd1);
        sample(32'h0000_0000, 1);
        tick(3);

        // 4a. arm coincident with matching strobe: ignored
        wr(2, 32'h0800_0000);
        do_arm();
        arm = 1'b1;
        sample(32'h0000_00A5, 0);
        arm = 1'b0;
        tick(2);
        chk("t4a_armed_after_arm_stb", {31'd0, armed}, 32'd1);
        sample(32'h0000_00A5, 1);
        tick(2);

        // 4b. reset during DELAY with cnt=2
        wr(2, 32'h0800_0003);
        do_arm();
        sample(32'h0000_00A5, 0);
        sample(32'h0000_0000, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t4b_idle_after_rst", {31'd0, armed}, 32'd0);
        sample(32'h0000_0000, 0);
        tick(2);
        sample(32'h0000_00A5, 0);
        tick(3);

        // 4c. mask zero matches on first strobe
        wr(0, 32'h0000_0000);
        wr(1, 32'h0000_0012);
        wr(2, 32'h0800_0000);
        do_arm();
        sample(32'h0000_DEAD, 1);
        tick(3);

        // 5. serial channel 5, mask 0xF, val 0xB, bit5 sequence 1,0,1,1
        wr(0, 32'h0000_000F);
        wr(1, 32'h0000_000B);
        wr(2, 32'h0C50_0000);
        do_arm();
        sample(32'h0000_0020, 0);
        sample(32'h0000_0000, 0);
        sample(32'h0000_0020, 0);
`ifdef TRG_SERIAL_EN
        sample(32'h0000_0020, 1);
        tick(2);
        sample(32'h0000_000B, 0);
`else
        sample(32'h0000_0020, 0);
        tick(2);
        sample(32'h0000_000B, 1);
`endif
        tick(4);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
